// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle unsigned multiply/divide unit, 16 iterations per op.
// It uses shift-add multiply and restoring divide, with a one-cycle write-back strobe for the register file.
`default_nettype none

module mul_div_unit #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [3:0]       dest,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic [WIDTH-1:0] C,
  output logic [3:0]       Caddr,
  output logic             Load,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t           state;
  logic [1:0]       op_q;
  logic [3:0]       dest_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH:0]   hi;
  logic [WIDTH-1:0] lo;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   hi_nxt;
  logic [WIDTH-1:0] lo_nxt;
  logic [WIDTH-1:0] result;
  logic             accept;

  // Multiply: hi:lo is the running product with the multiplier shifting out of lo.
  // Divide: hi is the 17-bit partial remainder, lo shifts dividend out and quotient in.
  always_comb begin
    mul_sum = {1'b0, hi[WIDTH-1:0]} + (lo[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    trial   = {hi[WIDTH-1:0], lo[WIDTH-1]};
    diff    = trial - {1'b0, b_q};
    hi_nxt  = hi;
    lo_nxt  = lo;
    if (!op_q[1]) begin
      hi_nxt = {1'b0, mul_sum[WIDTH:1]};
      lo_nxt = {mul_sum[0], lo[WIDTH-1:1]};
    end else if (diff[WIDTH]) begin
      hi_nxt = trial;
      lo_nxt = {lo[WIDTH-2:0], 1'b0};
    end else begin
      hi_nxt = diff;
      lo_nxt = {lo[WIDTH-2:0], 1'b1};
    end
    // MULLO/DIVQ come from lo, MULHI/DIVR from hi.
    result = op_q[0] ? hi_nxt[WIDTH-1:0] : lo_nxt;
  end

  // The write-back cycle can take a new request so back-to-back ops lose no cycle.
  assign accept = start && (state != RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      Load        <= 1'b0;
      C           <= '0;
      Caddr       <= '0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      hi          <= '0;
      lo          <= '0;
      op_q        <= '0;
      dest_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
    end else begin
      Load        <= 1'b0;
      div_by_zero <= 1'b0;
      if (accept) begin
        state  <= RUN;
        busy   <= 1'b1;
        op_q   <= op;
        dest_q <= dest;
        a_q    <= A;
        b_q    <= B;
        cnt    <= '0;
        hi     <= '0;
        lo     <= op[1] ? A : B;
      end else begin
        case (state)
          IDLE: begin
            busy <= 1'b0;
          end
          RUN: begin
            hi  <= hi_nxt;
            lo  <= lo_nxt;
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH - 1)) begin
              state       <= WB;
              Load        <= 1'b1;
              C           <= result;
              Caddr       <= dest_q;
              div_by_zero <= op_q[1] && (b_q == '0);
            end
          end
          WB: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire
